rr_grant_arbiter: RTL and testbench
===================================

Name: rr_grant_arbiter

Overview:
- Round-robin arbiter that grants one of N requesters access to a shared resource, such as the memory port shared by I-cache and D-cache.
- Produces a registered one-hot grant vector that directly drives the select of the downstream one-hot data/address mux, plus a binary index.
- Holds the grant for the whole transaction until the resource signals done, then rotates priority.

Parameters:
- N, 4, number of requesters (N >= 2).
- IDXW, $clog2(N), width of the binary grant index.
- TIMEOUT, 255, watchdog limit in cycles while busy (used only with ARB_TIMEOUT_EN).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  N  request vector; bit i = requester i wants the resource.
- done  input  1  single-cycle pulse from the shared resource: current transaction complete.
- grant  output  N  one-hot grant (all zero when idle); feeds the downstream mux select.
- grant_idx  output  IDXW  binary index of the granted requester (0 when idle).
- grant_valid  output  1  equals OR of grant.
- timeout  output  1  watchdog release pulse (tied 0 without ARB_TIMEOUT_EN).

Behaviour:
- Reset (async, rst_n=0), all forced immediately:
  - state=IDLE, grant=0, grant_idx=0, grant_valid=0, timeout=0.
  - Priority pointer ptr=0.
  - Watchdog counter=0.
- State machine has two states, IDLE and BUSY. All outputs are registered; none is combinational from req or done.
- IDLE:
  - At a rising edge with req != 0: select the first set bit of req scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap mod N).
  - Load grant with that one-hot bit and grant_idx with its index, then go to BUSY.
  - Latency: req sampled at edge t gives grant visible after edge t.
  - req == 0: stay IDLE with outputs zero.
  - done in IDLE: ignored.
- BUSY:
  - grant and grant_idx are held constant regardless of req changes, including the granted requester dropping its req.
  - At an edge with done=1: grant<=0, grant_idx<=0, ptr<=(grant_idx+1) mod N, go to IDLE.
  - A done in the first BUSY cycle is legal.
- Throughput: exactly one IDLE cycle between consecutive grants, so the best case is one grant every 2 cycles.
- grant never has more than one bit set, in any state or cycle.
- ptr changes only on transaction completion (done or watchdog release).
- Bits of req at index >= N do not exist. N that is not a power of two: indices wrap at N, not 2^IDXW.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on IDLE->BUSY and increments each BUSY cycle without done.
  - If the counter reaches TIMEOUT with no done, the next edge forces release exactly as done would: grant<=0, ptr advances, go to IDLE.
  - timeout pulses 1 for exactly one cycle, coincident with the first IDLE cycle.
  - done at the same edge as expiry: treated as a normal done, timeout stays 0.
- Not defined: no counter is built, timeout is constant 0, and BUSY waits for done indefinitely.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with req=1111 -> grant=0000, grant_valid=0, grant_idx=0 immediately. After release with req=1111 -> first grant=0001.
- Single requester: req=0100 at edge 1 -> grant=0100, grant_idx=2 after edge 1, held for 5 cycles with done=0. done at edge 6 -> grant=0000 after edge 6; ptr=3.
- Fairness: req=1111 held, done pulsed on every BUSY cycle -> grant sequence 0001, 0010, 0100, 1000, 0001, each separated by one zero cycle.
- Wrap and skip: ptr=3 (after serving requester 2), req=0011 -> grant=0001. Next, req=0010 -> grant=0010.
- Hold under req change: grant=0010 active, req changes 0010->1001->0000 before done -> grant stays 0010 until the done edge. Then req=1001 -> grant=1000.
- ARB_TIMEOUT_EN with TIMEOUT=8: grant=0001, done never asserted -> release after 8 BUSY cycles, timeout=1 for one cycle, ptr=1. Next req=0011 -> grant=0010.

Source files
------------

// File: rtl/rr_grant_arbiter_if.sv
// rr_grant_arbiter_if: request/grant bundle between requesters, shared resource and the round-robin arbiter.
interface rr_grant_arbiter_if #(
    parameter int N    = 4,
    parameter int IDXW = $clog2(N)
);
    logic [N-1:0]    req;
    logic            done;
    logic [N-1:0]    grant;
    logic [IDXW-1:0] grant_idx;
    logic            grant_valid;
    logic            timeout;

    modport slave (
        input  req, done,
        output grant, grant_idx, grant_valid, timeout
    );

    modport master (
        output req, done,
        input  grant, grant_idx, grant_valid, timeout
    );
endinterface

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: round-robin arbiter holding a registered one-hot grant until done.
// Define ARB_TIMEOUT_EN to add a watchdog that releases a grant after TIMEOUT busy cycles.
module rr_grant_arbiter #(
    parameter int N       = 4,
    parameter int IDXW    = $clog2(N),
    parameter int TIMEOUT = 255
) (
    input logic clk,
    input logic rst_n,
    rr_grant_arbiter_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [IDXW-1:0] sel;
    logic            expire;
    int              j;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    // Expiry is seen during the TIMEOUT-th busy cycle so release lands after exactly TIMEOUT cycles.
    assign expire = cnt_q >= CW'(TIMEOUT - 1);

    always_comb begin
        cnt_d     = (state_q == IDLE) ? '0 : cnt_q + 1'b1;
        timeout_d = (state_q == BUSY) && expire && !bus.done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign expire      = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    // Scan offsets from the far end so the closest set bit after ptr wins.
    always_comb begin
        sel = '0;
        j   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr_q) + k;
            if (j >= N) j = j - N;
            if (bus.req[j]) sel = IDXW'(j);
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        if (state_q == IDLE) begin
            if (|bus.req) begin
                grant_d      = '0;
                grant_d[sel] = 1'b1;
                idx_d        = sel;
                state_d      = BUSY;
            end
        end else if (bus.done || expire) begin
            grant_d = '0;
            idx_d   = '0;
            ptr_d   = (idx_q == IDXW'(N - 1)) ? '0 : idx_q + 1'b1;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = |grant_q;
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb_rr_grant_arbiter: directed and randomized checks of rr_grant_arbiter against a behavioural model.
module tb_rr_grant_arbiter;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int TO = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    rr_grant_arbiter_if #(.N(N), .IDXW(IW)) bus ();
    rr_grant_arbiter #(.N(N), .IDXW(IW), .TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total  = 0;
    int passed = 0;
    bit m_busy;
    bit m_to;
    int m_g, m_ptr, m_cnt;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_busy = 0; m_to = 0; m_g = 0; m_ptr = 0; m_cnt = 0;
    endtask

    task automatic check_model(string tag);
        chk({tag, ".grant"}, 32'(bus.grant), m_busy ? 32'(1) << m_g : 32'd0);
        chk({tag, ".idx"}, 32'(bus.grant_idx), m_busy ? 32'(m_g) : 32'd0);
        chk({tag, ".valid"}, 32'(bus.grant_valid), 32'(m_busy));
        chk({tag, ".timeout"}, 32'(bus.timeout), 32'(m_to));
    endtask

    // Reference: first requester at or after ptr (mod N) wins; completion moves ptr past the winner.
    task automatic model_edge(logic [N-1:0] r, logic d);
        m_to = 0;
        if (!m_busy) begin
            for (int o = 0; o < N; o++)
                if (!m_busy && r[(m_ptr + o) % N]) begin
                    m_busy = 1; m_g = (m_ptr + o) % N; m_cnt = 0;
                end
        end else begin
            m_cnt++;
            if (d || (TO_EN && m_cnt == TO)) begin
                m_to   = !d;
                m_busy = 0;
                m_ptr  = (m_g + 1) % N;
            end
        end
    endtask

    task automatic step(logic [N-1:0] r, logic d, string tag);
        @(negedge clk);
        bus.req  = r;
        bus.done = d;
        @(posedge clk);
        model_edge(r, d);
        #1 check_model(tag);
    endtask

    initial begin
        bus.req  = '0;
        bus.done = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_model("por");
        @(negedge clk) rst_n = 1'b1;

        step(4'b1111, 0, "rst_first");
        chk("rst_first_grant", 32'(bus.grant), 32'h1);
        step(4'b1111, 0, "rst_hold");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 model_reset();
        chk("async_grant", 32'(bus.grant), 32'h0);
        chk("async_valid", 32'(bus.grant_valid), 32'h0);
        chk("async_idx", 32'(bus.grant_idx), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        step(4'b1111, 0, "after_rst");
        chk("after_rst_grant", 32'(bus.grant), 32'h1);
        step(4'b0000, 1, "after_rst_done");

        step(4'b0100, 0, "single");
        chk("single_grant", 32'(bus.grant), 32'h4);
        chk("single_idx", 32'(bus.grant_idx), 32'h2);
        for (int i = 0; i < 5; i++) step(4'b0100, 0, "single_hold");
        step(4'b0000, 1, "single_done");
        chk("single_released", 32'(bus.grant), 32'h0);

        step(4'b0011, 0, "wrap");
        chk("wrap_grant", 32'(bus.grant), 32'h1);
        step(4'b0000, 1, "wrap_done");
        step(4'b0010, 0, "skip");
        chk("skip_grant", 32'(bus.grant), 32'h2);
        step(4'b1001, 0, "hold_a");
        step(4'b0000, 0, "hold_b");
        chk("hold_grant", 32'(bus.grant), 32'h2);
        step(4'b0000, 1, "hold_done");
        step(4'b1001, 0, "after_hold");
        chk("after_hold_grant", 32'(bus.grant), 32'h8);
        step(4'b0000, 1, "after_hold_done");

        for (int i = 0; i < 9; i++) begin
            step(4'b1111, 0, "fair");
            chk("fair_seq", 32'(bus.grant), 32'(1) << (i % N));
            step(4'b1111, 1, "fair_done");
        end

        step(4'b0000, 1, "idle_done");
        if (TO_EN) begin
            step(4'b0001, 0, "wd_grant");
            for (int i = 0; i < TO; i++) step(4'b0000, 0, "wd_wait");
            chk("wd_pulse", 32'(bus.timeout), 32'h1);
            step(4'b0011, 0, "wd_next");
            chk("wd_next_grant", 32'(bus.grant), 32'h2);
            step(4'b0000, 1, "wd_next_done");
        end

        for (int i = 0; i < 3000; i++)
            step(N'($urandom), $urandom_range(0, 3) == 0, "rand");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
